// File: rtl/ca_epl_correlator_if.sv
// Sample-in / dump-out bundle for the early-prompt-late C/A correlator.
// master drives samples and ack; slave (the correlator) returns the epoch sums.
interface ca_epl_correlator_if #(
    parameter int unsigned SAMPLE_WIDTH = 3,
    parameter int unsigned ACC_WIDTH    = 16
) ();
    logic                           enable;
    logic                           code_in;
    logic                           code_wrap;
    logic signed [SAMPLE_WIDTH-1:0] i_in;
    logic signed [SAMPLE_WIDTH-1:0] q_in;
    logic signed [ACC_WIDTH-1:0]    e_i;
    logic signed [ACC_WIDTH-1:0]    e_q;
    logic signed [ACC_WIDTH-1:0]    p_i;
    logic signed [ACC_WIDTH-1:0]    p_q;
    logic signed [ACC_WIDTH-1:0]    l_i;
    logic signed [ACC_WIDTH-1:0]    l_q;
    logic                           dump_valid;
    logic                           dump_ack;
    logic                           overrun;

    modport master (
        output enable, code_in, code_wrap, i_in, q_in, dump_ack,
        input  e_i, e_q, p_i, p_q, l_i, l_q, dump_valid, overrun
    );

    modport slave (
        input  enable, code_in, code_wrap, i_in, q_in, dump_ack,
        output e_i, e_q, p_i, p_q, l_i, l_q, dump_valid, overrun
    );
endinterface

// File: rtl/ca_epl_correlator.sv
// Early/prompt/late C/A code correlator: six I/Q accumulators dumped once per code epoch.
// Define CORR_SATURATE_EN to make every accumulator add saturate instead of wrapping.
module ca_epl_correlator #(
    parameter int unsigned SAMPLE_WIDTH = 3,
    parameter int unsigned ACC_WIDTH    = 16,
    parameter int unsigned EL_SPACING   = 2
) (
    input logic                clk_i,
    input logic                reset_ni,
    ca_epl_correlator_if.slave bus_io
);
    localparam int unsigned TapW   = 2 * EL_SPACING + 1;
    localparam int unsigned NumAcc = 6;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    logic [TapW-2:0] hist_q, hist_d;
    logic [TapW-1:0] taps;
    logic            dump_valid_q, dump_valid_d;
    logic            overrun_q, overrun_d;
    logic            new_dump;
    acc_t            i_ext, q_ext;

    function automatic acc_t acc_add(input acc_t a, input acc_t b);
        acc_t s;
        s = a + b;
`ifdef CORR_SATURATE_EN
        // Overflow only when both operands share a sign the sum does not.
        if ((a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1])) begin
            s = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    // Tap 0 is the live code bit, so only 2*EL_SPACING past bits are stored.
    assign taps     = {hist_q, bus_io.code_in};
    assign new_dump = bus_io.enable & bus_io.code_wrap;
    assign i_ext    = {{(ACC_WIDTH-SAMPLE_WIDTH){bus_io.i_in[SAMPLE_WIDTH-1]}}, bus_io.i_in};
    assign q_ext    = {{(ACC_WIDTH-SAMPLE_WIDTH){bus_io.q_in[SAMPLE_WIDTH-1]}}, bus_io.q_in};

    // Lane k: replica tap (k/2)*EL_SPACING, I for even k and Q for odd k.
    for (genvar k = 0; k < NumAcc; k++) begin : g_lane
        localparam int unsigned Tap = (k / 2) * EL_SPACING;

        acc_t ext, prod, sum;
        acc_t acc_q, acc_d;
        acc_t dump_q, dump_d;

        if (k % 2 == 0) begin : g_i
            assign ext = i_ext;
        end else begin : g_q
            assign ext = q_ext;
        end

        assign prod = taps[Tap] ? -ext : ext;
        assign sum  = acc_add(acc_q, prod);

        always_comb begin
            acc_d  = acc_q;
            dump_d = dump_q;
            if (bus_io.enable) begin
                if (bus_io.code_wrap) begin
                    dump_d = sum;
                    acc_d  = '0;
                end else begin
                    acc_d = sum;
                end
            end
        end

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                acc_q  <= '0;
                dump_q <= '0;
            end else begin
                acc_q  <= acc_d;
                dump_q <= dump_d;
            end
        end
    end

    always_comb begin
        hist_d       = hist_q;
        dump_valid_d = dump_valid_q;
        overrun_d    = overrun_q;
        if (bus_io.enable) begin
            hist_d = taps[TapW-2:0];
        end
        if (new_dump) begin
            dump_valid_d = 1'b1;
            if (dump_valid_q && !bus_io.dump_ack) begin
                overrun_d = 1'b1;
            end
        end else if (dump_valid_q && bus_io.dump_ack) begin
            dump_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hist_q       <= '0;
            dump_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            dump_valid_q <= dump_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus_io.e_i        = g_lane[0].dump_q;
    assign bus_io.e_q        = g_lane[1].dump_q;
    assign bus_io.p_i        = g_lane[2].dump_q;
    assign bus_io.p_q        = g_lane[3].dump_q;
    assign bus_io.l_i        = g_lane[4].dump_q;
    assign bus_io.l_q        = g_lane[5].dump_q;
    assign bus_io.dump_valid = dump_valid_q;
    assign bus_io.overrun    = overrun_q;
endmodule

// File: tb/tb_ca_epl_correlator.sv
// Bench for ca_epl_correlator: directed literal cases plus a randomized run checked
// every cycle against an integer epoch-sum model. Honors CORR_SATURATE_EN.
module tb_ca_epl_correlator;
    localparam int SW  = 3;
    localparam int AW  = 16;
    localparam int E   = 2;
    localparam int AW8 = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ca_epl_correlator_if #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW))  bus  ();
    ca_epl_correlator_if #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW8)) bus8 ();

    ca_epl_correlator #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW), .EL_SPACING(E)) dut (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .bus_io  (bus)
    );

    ca_epl_correlator #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW8), .EL_SPACING(E)) dut8 (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .bus_io  (bus8)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int hist[$];          // code bits, newest first; missing entries read as 0
    int m_acc[6];
    int m_dump[6];
    bit m_valid;
    bit m_overrun;

    function automatic int sx(input int v);
        logic signed [AW-1:0] t;
        t = v[AW-1:0];
        return int'(t);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 6; k++) begin
            m_acc[k]  = 0;
            m_dump[k] = 0;
        end
        m_valid   = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic model_step();
        int smp[2];
        int prod[6];
        int tap;
        bit neg;
        for (int k = 0; k < 6; k++) prod[k] = 0;
        if (bus.enable) begin
            hist.push_front(int'(bus.code_in));
            if (hist.size() > 2 * E + 1) void'(hist.pop_back());
            smp[0] = bus.i_in;
            smp[1] = bus.q_in;
            for (int k = 0; k < 6; k++) begin
                tap     = (k / 2) * E;
                neg     = (tap < hist.size()) && (hist[tap] != 0);
                prod[k] = neg ? -smp[k % 2] : smp[k % 2];
            end
        end
        if (bus.enable && bus.code_wrap) begin
            if (m_valid && !bus.dump_ack) m_overrun = 1'b1;
            m_valid = 1'b1;
            for (int k = 0; k < 6; k++) begin
                m_dump[k] = m_acc[k] + prod[k];
                m_acc[k]  = 0;
            end
        end else begin
            if (bus.enable) begin
                for (int k = 0; k < 6; k++) m_acc[k] += prod[k];
            end
            if (m_valid && bus.dump_ack) m_valid = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        string nm[6];
        int    act[6];
        nm = '{"e_i", "e_q", "p_i", "p_q", "l_i", "l_q"};
        forever begin
            @(negedge clk);
            act[0] = bus.e_i;
            act[1] = bus.e_q;
            act[2] = bus.p_i;
            act[3] = bus.p_q;
            act[4] = bus.l_i;
            act[5] = bus.l_q;
            for (int k = 0; k < 6; k++) chk({"model_", nm[k]}, act[k], sx(m_dump[k]));
            chk("model_dump_valid", int'(bus.dump_valid), int'(m_valid));
            chk("model_overrun", int'(bus.overrun), int'(m_overrun));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit en, input bit code, input bit wrap,
                         input int i, input int q, input bit ack);
        @(posedge clk);
        #1;
        bus.enable    = en;
        bus.code_in   = code;
        bus.code_wrap = wrap;
        bus.i_in      = SW'(i);
        bus.q_in      = SW'(q);
        bus.dump_ack  = ack;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.code_in    = 1'b0;
        bus.code_wrap  = 1'b0;
        bus.i_in       = '0;
        bus.q_in       = '0;
        bus.dump_ack   = 1'b0;
        bus8.enable    = 1'b0;
        bus8.code_in   = 1'b0;
        bus8.code_wrap = 1'b0;
        bus8.i_in      = '0;
        bus8.q_in      = '0;
        bus8.dump_ack  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_dump_valid", int'(bus.dump_valid), 0);
        chk("reset_overrun", int'(bus.overrun), 0);
        chk("reset_p_i", int'(bus.p_i), 0);
        rst_n = 1'b1;

        // Constant input, one 10-sample epoch.
        for (int n = 1; n <= 10; n++) drive(1'b1, 1'b0, n == 10, 1, -2, 1'b0);
        idle();
        chk("const_e_i", int'(bus.e_i), 10);
        chk("const_p_i", int'(bus.p_i), 10);
        chk("const_l_i", int'(bus.l_i), 10);
        chk("const_e_q", int'(bus.e_q), -20);
        chk("const_l_q", int'(bus.l_q), -20);
        chk("const_valid", int'(bus.dump_valid), 1);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        idle();
        chk("const_ack_valid", int'(bus.dump_valid), 0);

        // Tap alignment: single code 1 at sample 3 of 6.
        for (int n = 1; n <= 6; n++) drive(1'b1, n == 3, n == 6, 3, 0, 1'b0);
        idle();
        chk("tap_e_i", int'(bus.e_i), 12);
        chk("tap_p_i", int'(bus.p_i), 12);
        chk("tap_l_i", int'(bus.l_i), 18);
        chk("tap_p_q", int'(bus.p_q), 0);

        // Gapped epoch, unacked: garbage in enable=0 cycles; late tap sees the old 1.
        for (int n = 1; n <= 4; n++) begin
            drive(1'b0, 1'b1, 1'b1, -4, 3, 1'b0);
            drive(1'b1, 1'b0, n == 4, 1, 1, 1'b0);
        end
        idle();
        chk("gap_e_i", int'(bus.e_i), 4);
        chk("gap_p_q", int'(bus.p_q), 4);
        chk("gap_l_i", int'(bus.l_i), 2);
        chk("gap_l_q", int'(bus.l_q), 2);
        chk("gap_overrun", int'(bus.overrun), 1);
        chk("gap_valid", int'(bus.dump_valid), 1);

        // Ack coincident with the next wrap.
        drive(1'b1, 1'b0, 1'b0, -4, -1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, -4, -1, 1'b1);
        idle();
        chk("ackwrap_e_i", int'(bus.e_i), -8);
        chk("ackwrap_e_q", int'(bus.e_q), -2);
        chk("ackwrap_l_i", int'(bus.l_i), -8);
        chk("ackwrap_valid", int'(bus.dump_valid), 1);
        chk("ackwrap_overrun", int'(bus.overrun), 1);

        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        idle();
        chk("ack_valid", int'(bus.dump_valid), 0);
        chk("ack_overrun", int'(bus.overrun), 1);

        // Asynchronous reset mid-cycle clears outputs before any clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_overrun", int'(bus.overrun), 0);
        chk("async_e_i", int'(bus.e_i), 0);
        chk("async_valid", int'(bus.dump_valid), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) drive(1'b1, 1'b0, 1'b0, 2, 2, 1'b0);
        idle();
        chk("postreset_no_dump", int'(bus.dump_valid), 0);

        // 50 samples of +3 into the 8-bit instance.
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            bus8.enable    = 1'b1;
            bus8.i_in      = 3'sd3;
            bus8.code_wrap = (n == 50);
        end
        @(posedge clk);
        #1;
        bus8.enable    = 1'b0;
        bus8.code_wrap = 1'b0;
`ifdef CORR_SATURATE_EN
        chk("sat_p_i", int'(bus8.p_i), 127);
        chk("sat_e_i", int'(bus8.e_i), 127);
`else
        chk("wrap_p_i", int'(bus8.p_i), -106);
        chk("wrap_e_i", int'(bus8.e_i), -106);
`endif
        chk("sat_valid", int'(bus8.dump_valid), 1);

        // Randomized run with one asynchronous reset in the middle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 11) == 0),
                  int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4,
                  ($urandom_range(0, 2) == 0));
            if (cyc == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rnd_async_valid", int'(bus.dump_valid), 0);
            end
            if (cyc == 1503) begin
                #2;
                rst_n = 1'b1;
            end
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
